// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU exerciser front end:
//   - fixed widths (data, control code, flags, result buffer)
//   - ALU control code constants
//   - exerciser FSM state type
//   - result buffer entry layout {result, ovf, zero, co}
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int CTR_W     = 3;
    localparam int FLAG_W    = 3;
    localparam int BUF_DEPTH = 8;
    localparam int ENTRY_W   = DATA_W + FLAG_W;

    // ALU control codes; 011, 100 and 101 select constant results
    localparam logic [CTR_W-1:0] ALU_AND    = 3'b000;
    localparam logic [CTR_W-1:0] ALU_OR     = 3'b001;
    localparam logic [CTR_W-1:0] ALU_ADD    = 3'b010;
    localparam logic [CTR_W-1:0] ALU_CONST3 = 3'b011;
    localparam logic [CTR_W-1:0] ALU_CONST4 = 3'b100;
    localparam logic [CTR_W-1:0] ALU_CONST5 = 3'b101;
    localparam logic [CTR_W-1:0] ALU_SUB    = 3'b110;
    localparam logic [CTR_W-1:0] ALU_SLT    = 3'b111;

    // First and last code visited by a sweep
    localparam logic [CTR_W-1:0] SWEEP_FIRST = ALU_AND;
    localparam logic [CTR_W-1:0] SWEEP_LAST  = ALU_SLT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Flag ordering used everywhere: {ovf, zero, co}
    function automatic logic [FLAG_W-1:0] pack_flags(input logic ovf,
                                                     input logic zero,
                                                     input logic co);
        return {ovf, zero, co};
    endfunction

endpackage

// File: rtl/alu_result_buf.sv
// ---------------------------------------------------------------------------
// alu_result_buf
// 8 x 35 register file holding captured ALU results and flags.
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high clear of every entry
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   entry to write {result[31:0], ovf, zero, co}
//   raddr  in   read index
//   rdata  out  entry at raddr, combinational (old value until write edge)
// ---------------------------------------------------------------------------
module alu_result_buf
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [CTR_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [CTR_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_exerciser.sv
// ---------------------------------------------------------------------------
// alu_exerciser
// Initiator front end for a combinational 32-bit ALU. Loads operands from a
// data bus, issues either one control code or all eight codes on a go strobe,
// and captures every result and its flags into an 8-entry buffer.
//   clk, rst                 clock (rising edge), async active-high reset
//   din, ld_a, ld_b          operand bus and load strobes (IDLE only)
//   op, sweep, go            run request: single code op, or sweep 0..7
//   alu_a, alu_b, alu_ctr    operands and control code driven to the ALU
//   alu_res, alu_co,
//   alu_zero, alu_ovf        ALU result and flags, sampled at end of ISSUE
//   busy, done               run in progress / one-cycle end-of-run pulse
//   res, flags               last captured result and {ovf, zero, co}
//   rd_idx, rd_data,
//   rd_flags                 combinational result buffer read port
// ---------------------------------------------------------------------------
module alu_exerciser
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              ld_a,
    input  logic              ld_b,
    input  logic [CTR_W-1:0]  op,
    input  logic              sweep,
    input  logic              go,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTR_W-1:0]  alu_ctr,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_co,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] res,
    output logic [FLAG_W-1:0] flags,
    input  logic [CTR_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [FLAG_W-1:0] rd_flags
);

    state_t              state;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [CTR_W-1:0]    ctr_q;
    logic                mode_q;     // 1 = sweep run
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   res_q;
    logic [FLAG_W-1:0]   flags_q;

    logic [FLAG_W-1:0]   alu_flags;
    logic [ENTRY_W-1:0]  buf_rdata;

    assign alu_flags = pack_flags(alu_ovf, alu_zero, alu_co);

    // A load and a go in the same IDLE cycle both land on one edge, so the
    // first ISSUE cycle already presents the freshly loaded operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctr_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_a) a_q <= din;
                    if (ld_b) b_q <= din;
                    if (go) begin
                        ctr_q  <= sweep ? SWEEP_FIRST : op;
                        mode_q <= sweep;
                        busy_q <= 1'b1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    res_q   <= alu_res;
                    flags_q <= alu_flags;
                    if (!mode_q || ctr_q == SWEEP_LAST) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        ctr_q <= ctr_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Every ISSUE cycle files its result under the code that produced it
    alu_result_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (state == ST_ISSUE),
        .waddr (ctr_q),
        .wdata ({alu_res, alu_flags}),
        .raddr (rd_idx),
        .rdata (buf_rdata)
    );

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctr  = ctr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign res      = res_q;
    assign flags    = flags_q;
    assign rd_data  = buf_rdata[ENTRY_W-1:FLAG_W];
    assign rd_flags = buf_rdata[FLAG_W-1:0];

endmodule

// File: tb/tb_alu_exerciser.sv
// ---------------------------------------------------------------------------
// tb_alu_exerciser
// Drives the exerciser with directed and random traffic, provides a
// combinational ALU behind it, and checks every output each cycle against a
// transaction-level model (queue of pending codes plus an expected buffer).
// ---------------------------------------------------------------------------
module tb_alu_exerciser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        ld_a = 1'b0, ld_b = 1'b0, sweep = 1'b0, go = 1'b0;
    logic [2:0]  op = '0, rd_idx = '0;
    logic [31:0] alu_a, alu_b, alu_res, res, rd_data;
    logic [2:0]  alu_ctr, flags, rd_flags;
    logic        alu_co, alu_zero, alu_ovf, busy, done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_exerciser dut (
        .clk(clk), .rst(rst), .din(din), .ld_a(ld_a), .ld_b(ld_b), .op(op),
        .sweep(sweep), .go(go), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctr(alu_ctr), .alu_res(alu_res), .alu_co(alu_co),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .busy(busy), .done(done),
        .res(res), .flags(flags), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_flags(rd_flags)
    );

    // Reference ALU: returns {result, ovf, zero, co}
    function automatic logic [34:0] alu_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  code);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        co = 1'b0; ov = 1'b0; r = '0;
        case (code)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd3: r = 32'hA5A5A5A5;
            3'd4: r = 32'hA5A5A5A5;
            3'd5: r = 32'h5A5A5A5A;
            3'd6: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = (a < b) ? 32'd1 : 32'd0;
        endcase
        return {r, ov, (r == 32'd0), co};
    endfunction

    logic [34:0] alu_out;
    always_comb begin
        alu_out  = alu_fn(alu_a, alu_b, alu_ctr);
        alu_res  = alu_out[34:3];
        alu_ovf  = alu_out[2];
        alu_zero = alu_out[1];
        alu_co   = alu_out[0];
    end

    // ---------------- behavioural model ----------------
    logic [31:0] exp_a = '0, exp_b = '0, exp_res = '0;
    logic [2:0]  exp_ctr = '0, exp_flags = '0;
    logic [34:0] exp_buf [8];
    logic [2:0]  pend_q [$];
    bit          done_due = 1'b0;
    logic [2:0]  m_code;
    logic [34:0] m_val;

    task automatic model_reset();
        exp_a = '0; exp_b = '0; exp_res = '0; exp_ctr = '0; exp_flags = '0;
        pend_q.delete();
        done_due = 1'b0;
        for (int i = 0; i < 8; i++) exp_buf[i] = '0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else if (pend_q.size() != 0) begin
            m_code = pend_q.pop_front();
            m_val = alu_fn(exp_a, exp_b, m_code);
            exp_res = m_val[34:3];
            exp_flags = m_val[2:0];
            exp_buf[m_code] = m_val;
            if (pend_q.size() == 0) done_due = 1'b1;
            else exp_ctr = pend_q[0];
        end else if (done_due) begin
            done_due = 1'b0;
        end else begin
            if (ld_a) exp_a = din;
            if (ld_b) exp_b = din;
            if (go) begin
                if (sweep) for (int c = 0; c < 8; c++) pend_q.push_back(3'(c));
                else pend_q.push_back(op);
                exp_ctr = pend_q[0];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("alu_a", alu_a, exp_a);
            chk("alu_b", alu_b, exp_b);
            chk("alu_ctr", 32'(alu_ctr), 32'(exp_ctr));
            chk("busy", 32'(busy), 32'((pend_q.size() != 0) || done_due));
            chk("done", 32'(done), 32'(done_due));
            chk("res", res, exp_res);
            chk("flags", 32'(flags), 32'(exp_flags));
            chk("rd_data", rd_data, exp_buf[rd_idx][34:3]);
            chk("rd_flags", 32'(rd_flags), 32'(exp_buf[rd_idx][2:0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); din = a; ld_a = 1'b1;
        @(negedge clk); ld_a = 1'b0; din = b; ld_b = 1'b1;
        @(negedge clk); ld_b = 1'b0;
    endtask

    // Start a run and measure cycles from the go edge to the done pulse.
    // With poke set, busy-time strobes are thrown at the block mid-run.
    task automatic run(input logic [2:0] code, input bit sw, input int lat,
                       input bit poke);
        int n;
        n = 0;
        @(negedge clk); go = 1'b1; op = code; sweep = sw;
        while (n < 20) begin
            @(negedge clk);
            n++;
            go = 1'b0; ld_a = 1'b0; sweep = 1'b0;
            if (poke && n == 3) begin
                go = 1'b1; ld_a = 1'b1; din = 32'h12345678; op = 3'd5;
            end
            #1;
            if (done) break;
        end
        chk("latency", 32'(n), 32'(lat));
    endtask

    task automatic rd_chk(input logic [2:0] idx, input logic [31:0] d,
                          input logic [2:0] f);
        @(negedge clk); rd_idx = idx; #2;
        chk("lit_rd_data", rd_data, d);
        chk("lit_rd_flags", 32'(rd_flags), 32'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res", res, 32'd0);
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 32'd0, 3'd0);

        // single ADD
        load(32'd5, 32'd3);
        run(3'b010, 1'b0, 2, 1'b0);
        #3; chk("lit_add_res", res, 32'h00000008);
        chk("lit_add_flags", 32'(flags), 32'd0);
        rd_chk(3'd2, 32'h00000008, 3'b000);

        // single SUB
        load(32'd3, 32'd5);
        run(3'b110, 1'b0, 2, 1'b0);
        #3; chk("lit_sub_res", res, 32'hFFFFFFFE);
        rd_chk(3'd6, 32'hFFFFFFFE, 3'b000);

        // sweep with busy-time interference
        load(32'hF0F0F0F0, 32'h0FF00FF0);
        run(3'd3, 1'b1, 9, 1'b1);
        @(negedge clk); #2;
        chk("lit_a_kept", alu_a, 32'hF0F0F0F0);
        chk("lit_idle", 32'(busy), 32'd0);
        rd_chk(3'd0, 32'h00F000F0, 3'b000);
        rd_chk(3'd1, 32'hFFF0FFF0, 3'b000);
        rd_chk(3'd2, 32'h00E100E0, 3'b001);
        rd_chk(3'd3, 32'hA5A5A5A5, 3'b000);
        rd_chk(3'd4, 32'hA5A5A5A5, 3'b000);
        rd_chk(3'd5, 32'h5A5A5A5A, 3'b000);
        rd_chk(3'd7, 32'h00000000, 3'b010);

        // reset during the 4th ISSUE cycle of a sweep
        @(negedge clk); go = 1'b1; sweep = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk); go = 1'b0; sweep = 1'b0;
        end
        #2; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk); #2;
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_a", alu_a, 32'd0);
        chk("abort_b", alu_b, 32'd0);
        for (int i = 0; i < 8; i++) rd_chk(3'(i), 32'd0, 3'd0);

        // load A and go in the same IDLE cycle
        load(32'd0, 32'd1);
        @(negedge clk); din = 32'd7; ld_a = 1'b1; op = 3'b010;
        run(3'b010, 1'b0, 2, 1'b0);
        #3; chk("lit_ld_go_res", res, 32'h00000008);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            din    = $urandom;
            ld_a   = ($urandom_range(3) == 0);
            ld_b   = ($urandom_range(3) == 0);
            go     = ($urandom_range(5) == 0);
            op     = 3'($urandom);
            sweep  = ($urandom_range(3) == 0);
            rd_idx = 3'($urandom);
        end
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0; go = 1'b0; sweep = 1'b0;
        repeat (12) @(negedge clk);
        #3;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exerciser.md
# alu_exerciser

Sequencing front end that drives the 32-bit ALU's operand and control inputs and captures its outputs. Operands load from a 32-bit data bus; on a start pulse the block issues one operation, or sweeps all eight ALU control codes. Each result and its flags are registered into an 8-entry result buffer. It sits between the board I/O (switches/buttons) and the combinational ALU and acts as the initiator side of the ALU interface.

## Interface
- No parameters; widths fixed: data 32, control 3, buffer depth 8.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  32  operand data
- ld_a  in  1  load din into A register (IDLE only)
- ld_b  in  1  load din into B register (IDLE only)
- op  in  3  ALU control code for single-shot run
- sweep  in  1  sampled with go: 1 = run codes 0..7, 0 = run op once
- go  in  1  start strobe (IDLE only)
- alu_a  out  32  operand A to ALU (A register)
- alu_b  out  32  operand B to ALU (B register)
- alu_ctr  out  3  ALU control code (ctr register)
- alu_res  in  32  ALU result
- alu_co, alu_zero, alu_ovf  in  1 each  ALU flags
- busy  out  1  high in ISSUE and DONE
- done  out  1  one-cycle pulse at end of run
- res  out  32  last captured result
- flags  out  3  last captured {ovf, zero, co}
- rd_idx  in  3  buffer read index
- rd_data  out  32  buffer[rd_idx] result, combinational read
- rd_flags  out  3  buffer[rd_idx] {ovf, zero, co}

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: ld_a/ld_b update A/B at the clock edge. If go=1: ctr <= (sweep ? 0 : op), mode <= sweep, next state ISSUE. ld_a and go in the same cycle: the new A is used, because A and ctr update at the same edge.
- ISSUE: alu_a/alu_b/alu_ctr are stable for the whole cycle. At the closing edge, res <= alu_res, flags <= {alu_ovf, alu_zero, alu_co}, buffer[ctr] <= same.
  - Single mode: next state DONE.
  - Sweep mode: if ctr≠7, ctr <= ctr+1 and stay in ISSUE; if ctr=7, go to DONE. ctr does not wrap.
- DONE: done=1 for exactly one cycle, then IDLE. ctr holds its last value.
- go, ld_a, ld_b and changes to op/sweep are ignored while busy=1.
- The ALU is purely combinational. The block adds no settling cycles and samples at the end of the issue cycle.

## Timing
- Reset (async, immediate): state=IDLE; A, B, ctr, res, flags = 0; all buffer entries = 0; busy=0, done=0.
- Single run: go sampled at edge k → ISSUE during cycle k..k+1 → done high in cycle k+1..k+2 → busy low again after edge k+2. Latency from go to done is 2 cycles.
- Sweep run: 8 ISSUE cycles, done 9 cycles after the go edge.
- rst asserted mid-run: run aborts with no done pulse, and buffer contents are cleared.
- rd_data/rd_flags track rd_idx combinationally. A read of the entry being written returns the old value until the edge.

## Structure
- Shared package alu_pkg holds:
  - ALU code constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111; 011, 100 and 101 are the constant codes.
  - FSM state encoding for IDLE/ISSUE/DONE.
- One sub-module: alu_result_buf, an 8×35 register file with async clear, one write port (we, waddr, wdata) and one combinational read port.
- The FSM, operand registers and ctr register live in the top module.

## Test plan
- A=5, B=3, go with op=010, sweep=0 → alu_ctr=010 for one cycle; res=00000008, co=0; done pulses 2 cycles after go; buffer[2]=00000008.
- A=3, B=5, op=110 → res=FFFFFFFE, co=0; rd_idx=6 returns FFFFFFFE.
- A=F0F0F0F0, B=0FF00FF0, sweep=1 → alu_ctr steps 0..7 on consecutive cycles; done 9 cycles after go. Buffer: [0]=00F000F0, [1]=FFF0FFF0, [2]=00E100E0 with co=1, [3]=A5A5A5A5, [4]=A5A5A5A5, [5]=5A5A5A5A, [7]=00000000.
- During a sweep, pulse go, ld_a with din=12345678, and change op → no restart; A unchanged; sweep completes normally.
- Assert rst during the 4th ISSUE cycle of a sweep → busy=0, done never pulses, res=0, all buffer entries read 0, alu_a=alu_b=0.
- ld_a (din=7) and go (op=010, B=1) in the same IDLE cycle → res=00000008.
